psum_accumulator: RTL and testbench
===================================

# psum_accumulator

Downstream consumer of the systolic array's bottom-row partial sums. It accumulates the per-column psum vector over a programmed number of valid beats (one beat per input-channel tile) into per-column accumulators. It then drains the finished column totals one column per transfer over a valid/ready stream toward the output buffer. The accumulator lets one output tile span more input channels than a single pass of the array can hold.

## Interface
- ARRAY_SIZE, 8, number of array columns (psum vector lanes)
- LOG_ARRAY_SIZE, 3, log2(ARRAY_SIZE)
- COL_WIDTH, 10+LOG_ARRAY_SIZE, array column width; one psum lane is COL_WIDTH*4 bits
- ACC_WIDTH, 64, accumulator width; must be >= COL_WIDTH*4
- PASS_WIDTH, 8, width of the pass-count field
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to begin a new tile; honoured only in IDLE
- num_passes  input  PASS_WIDTH  beats to accumulate; sampled with start; 0 means start is ignored
- psum_valid  input  1  psums carries a valid beat this cycle
- psums  input  ARRAY_SIZE x (COL_WIDTH*4)  per-column signed two's-complement partial sums
- out_valid  output  1  out_data/out_col hold a finished column
- out_ready  input  1  consumer accepts the current column
- out_data  output  ACC_WIDTH  signed accumulated total for column out_col
- out_col  output  LOG_ARRAY_SIZE  column index, 0..ARRAY_SIZE-1
- out_last  output  1  high with out_valid when out_col == ARRAY_SIZE-1
- busy  output  1  state != IDLE
- dropped  output  1  sticky flag: a psum_valid beat arrived outside ACCUM; cleared by an accepted start

## Operation
- FSM states: IDLE, ACCUM, DRAIN.
- IDLE -> ACCUM when start && num_passes != 0. Actions on that transition:
  - latch num_passes into pass_target;
  - clear beat counter;
  - clear dropped.
- ACCUM: each psum_valid beat updates every column c.
  - First beat (count == 0): acc[c] = sext(psums[c]). No separate clear cycle is needed.
  - Later beats: acc[c] = acc[c] + sext(psums[c]), modulo 2^ACC_WIDTH (wrap, no saturation, no flag).
  - count increments per beat. The beat that makes count == pass_target moves the FSM to DRAIN.
- DRAIN: col pointer starts at 0.
  - out_data = acc[col], out_col = col.
  - On out_valid && out_ready, col increments.
  - A transfer with col == ARRAY_SIZE-1 moves the FSM to IDLE.
- psum_valid in IDLE or DRAIN: the beat is discarded, dropped is set, and accumulators are unchanged.
- start outside IDLE is ignored with no side effect. start with num_passes == 0 is ignored.
- start and psum_valid in the same IDLE cycle: the beat is discarded and dropped is set. The accepted start then clears dropped, so dropped reads 0 afterwards (start wins).

## Timing
- Reset (async assert, sync-safe deassert): state = IDLE, acc = 0, count = 0, col = 0, out_valid = 0, out_col = 0, out_data = 0, out_last = 0, busy = 0, dropped = 0.
- start accepted at edge k: busy = 1 from cycle k+1. The first beat can count at edge k+1.
- Last beat at edge m: out_valid = 1 and out_col = 0 from cycle m+1. Latency from last beat to first column is 1 cycle.
- out_valid stays high through DRAIN. out_data/out_col are stable while out_valid && !out_ready.
- Full drain takes ARRAY_SIZE cycles with out_ready held high. busy drops the cycle after the out_last transfer.
- A new start is accepted at the earliest in the cycle after busy falls.
- Reset asserted mid-ACCUM or mid-DRAIN returns all outputs to reset values immediately; the partial tile is lost.

## Test plan
- Single pass: start, num_passes=1; one beat with psums[c]=c+1 -> 8 transfers, out_data=1..8, out_col=0..7, out_last only on col 7, busy low afterwards.
- Multi-pass signed: num_passes=3; beats all columns +100, -250, +7 -> every column out_data = -143 (sign-extended to 64 bits).
- Backpressure: out_ready toggled 1,0,0,1,... during drain -> no column skipped or duplicated; data held stable during stalls; exactly 8 transfers.
- Ignored requests: start with num_passes=0 -> busy stays 0. start during DRAIN -> no effect, drain completes normally.
- dropped flag: psum_valid in IDLE -> dropped=1; next accepted start -> dropped=0. psum_valid during DRAIN -> dropped=1 and out_data unchanged.
- Reset mid-drain: rst_n low after col 3 transfers -> outputs zero immediately. After release, a fresh 1-pass tile drains from col 0 with correct sums.

Source files
------------

// File: rtl/psum_accumulator.sv
// psum_accumulator: sums the array's bottom-row psum vector over a programmed
// number of beats into per-column accumulators. It then drains the column
// totals one per transfer over a valid/ready stream.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start, num_passes    tile request (honoured in IDLE, num_passes != 0)
//   psum_valid, psums    per-beat psum vector, ARRAY_SIZE signed lanes
//   out_valid/out_ready  drain handshake
//   out_data, out_col    accumulated column total and its index
//   out_last             marks the final column of a drain
//   busy                 tile in progress
//   dropped              sticky: a beat arrived outside accumulation
module psum_accumulator #(
    parameter int unsigned ARRAY_SIZE     = 8,
    parameter int unsigned LOG_ARRAY_SIZE = 3,
    parameter int unsigned COL_WIDTH      = 10 + LOG_ARRAY_SIZE,
    parameter int unsigned ACC_WIDTH      = 64,
    parameter int unsigned PASS_WIDTH     = 8
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic [PASS_WIDTH-1:0]                   num_passes,
    input  logic                                    psum_valid,
    input  logic [ARRAY_SIZE*COL_WIDTH*4-1:0]       psums,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [ACC_WIDTH-1:0]                    out_data,
    output logic [LOG_ARRAY_SIZE-1:0]               out_col,
    output logic                                    out_last,
    output logic                                    busy,
    output logic                                    dropped
);

    localparam int unsigned LANE_W = COL_WIDTH * 4;
    localparam logic [LOG_ARRAY_SIZE-1:0] LAST_COL = LOG_ARRAY_SIZE'(ARRAY_SIZE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;

    logic [ACC_WIDTH-1:0]       r_acc [ARRAY_SIZE];
    logic [ACC_WIDTH-1:0]       w_sum [ARRAY_SIZE];
    logic [PASS_WIDTH-1:0]      r_count;
    logic [PASS_WIDTH-1:0]      r_pass_target;
    logic [LOG_ARRAY_SIZE-1:0]  r_col;

    logic                       r_out_valid;
    logic [ACC_WIDTH-1:0]       r_out_data;
    logic [LOG_ARRAY_SIZE-1:0]  r_out_col;
    logic                       r_out_last;
    logic                       r_busy;
    logic                       r_dropped;

    logic [PASS_WIDTH-1:0]      w_count_nxt;
    logic [PASS_WIDTH-1:0]      w_pass_nxt;
    logic [LOG_ARRAY_SIZE-1:0]  w_col_nxt;
    logic                       w_out_valid_nxt;
    logic [ACC_WIDTH-1:0]       w_out_data_nxt;
    logic [LOG_ARRAY_SIZE-1:0]  w_out_col_nxt;
    logic                       w_out_last_nxt;
    logic                       w_busy_nxt;
    logic                       w_dropped_nxt;

    logic                       w_start_ok;
    logic                       w_beat;
    logic [PASS_WIDTH-1:0]      w_count_inc;
    logic                       w_last_beat;
    logic                       w_xfer;
    logic                       w_last_xfer;

    assign w_start_ok  = (r_state == S_IDLE) && start && (num_passes != '0);
    assign w_beat      = (r_state == S_ACCUM) && psum_valid;
    assign w_count_inc = r_count + PASS_WIDTH'(1);
    assign w_last_beat = w_beat && (w_count_inc == r_pass_target);
    assign w_xfer      = (r_state == S_DRAIN) && r_out_valid && out_ready;
    assign w_last_xfer = w_xfer && (r_col == LAST_COL);

    // First beat of a tile overwrites instead of adding, so no clear cycle is needed
    always_comb begin
        for (int c = 0; c < int'(ARRAY_SIZE); c++) begin
            w_sum[c] = ((r_count == '0) ? '0 : r_acc[c])
                     + ACC_WIDTH'($signed(psums[c*LANE_W +: LANE_W]));
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok)  w_state_nxt = S_ACCUM;
            S_ACCUM: if (w_last_beat) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_last_xfer) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        w_count_nxt    = r_count;
        w_pass_nxt     = r_pass_target;
        w_col_nxt      = r_col;
        w_dropped_nxt  = r_dropped;
        w_out_data_nxt = r_out_data;

        if (w_start_ok) begin
            w_pass_nxt  = num_passes;
            w_count_nxt = '0;
        end
        if (w_beat) begin
            w_count_nxt = w_count_inc;
        end

        if (w_last_beat) begin
            w_col_nxt = '0;
        end else if (w_xfer) begin
            w_col_nxt = r_col + LOG_ARRAY_SIZE'(1);
        end

        // An accepted start clears the flag even if a stray beat arrives with it
        if (psum_valid && (r_state != S_ACCUM)) begin
            w_dropped_nxt = 1'b1;
        end
        if (w_start_ok) begin
            w_dropped_nxt = 1'b0;
        end

        if (w_state_nxt == S_DRAIN) begin
            if (w_last_beat) begin
                w_out_data_nxt = w_sum[0];
            end else if (w_xfer) begin
                w_out_data_nxt = r_acc[w_col_nxt];
            end
        end else begin
            w_out_data_nxt = '0;
        end

        w_out_valid_nxt = (w_state_nxt == S_DRAIN);
        w_busy_nxt      = (w_state_nxt != S_IDLE);
        w_out_col_nxt   = (w_state_nxt == S_DRAIN) ? w_col_nxt : '0;
        w_out_last_nxt  = (w_state_nxt == S_DRAIN) && (w_col_nxt == LAST_COL);
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < int'(ARRAY_SIZE); c++) begin
                r_acc[c] <= '0;
            end
            r_count       <= '0;
            r_pass_target <= '0;
            r_col         <= '0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_col     <= '0;
            r_out_last    <= 1'b0;
            r_busy        <= 1'b0;
            r_dropped     <= 1'b0;
        end else begin
            if (w_beat) begin
                for (int c = 0; c < int'(ARRAY_SIZE); c++) begin
                    r_acc[c] <= w_sum[c];
                end
            end
            r_count       <= w_count_nxt;
            r_pass_target <= w_pass_nxt;
            r_col         <= w_col_nxt;
            r_out_valid   <= w_out_valid_nxt;
            r_out_data    <= w_out_data_nxt;
            r_out_col     <= w_out_col_nxt;
            r_out_last    <= w_out_last_nxt;
            r_busy        <= w_busy_nxt;
            r_dropped     <= w_dropped_nxt;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_col   = r_out_col;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_psum_accumulator.sv
// Randomized bench for psum_accumulator against a column-sum reference model.
module tb_psum_accumulator;

    localparam int NCOL   = 8;
    localparam int LANE_W = 52;
    localparam int MAXB   = 16;

    logic                    clk;
    logic                    rst_n;
    logic                    start;
    logic [7:0]              num_passes;
    logic                    psum_valid;
    logic [NCOL*LANE_W-1:0]  psums;
    logic                    out_valid;
    logic                    out_ready;
    logic [63:0]             out_data;
    logic [2:0]              out_col;
    logic                    out_last;
    logic                    busy;
    logic                    dropped;

    int n_checks;
    int n_errors;

    longint beat [MAXB][NCOL];
    longint exp_v [NCOL];

    psum_accumulator dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .num_passes (num_passes),
        .psum_valid (psum_valid),
        .psums      (psums),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_col    (out_col),
        .out_last   (out_last),
        .busy       (busy),
        .dropped    (dropped)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    function automatic longint rand_lane();
        logic [63:0] r;
        r = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) return longint'($urandom_range(0, 2000)) - 1000;
        return $signed(r) >>> 12;
    endfunction

    task automatic fill_random(input int np);
        for (int b = 0; b < np; b++)
            for (int c = 0; c < NCOL; c++)
                beat[b][c] = rand_lane();
    endtask

    task automatic drive_beat(input int b);
        for (int c = 0; c < NCOL; c++)
            psums[c*LANE_W +: LANE_W] = LANE_W'(beat[b][c]);
    endtask

    task automatic drive_noise();
        for (int c = 0; c < NCOL; c++)
            psums[c*LANE_W +: LANE_W] = LANE_W'(rand_lane());
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},  64'(busy), 64'd0);
        chk({tag, "_ov"},    64'(out_valid), 64'd0);
        chk({tag, "_data"},  out_data, 64'd0);
        chk({tag, "_col"},   64'(out_col), 64'd0);
        chk({tag, "_last"},  64'(out_last), 64'd0);
        chk({tag, "_drop"},  64'(dropped), 64'd0);
    endtask

    // mode: 0 ready always, 1 pattern 1,0,0,1, 2 random
    task automatic run_tile(input int np, input int mode, input bit noise,
                            input bit sv, input int abort_at);
        int  b;
        int  idx;
        int  cyc;
        bit  rdy;
        bit  noise_seen;
        for (int c = 0; c < NCOL; c++) begin
            exp_v[c] = 0;
            for (int k = 0; k < np; k++) exp_v[c] += beat[k][c];
        end

        @(negedge clk);
        start      = 1'b1;
        num_passes = 8'(np);
        psum_valid = sv;
        drive_noise();
        @(negedge clk);
        start      = 1'b0;
        psum_valid = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_drop", 64'(dropped), 64'd0);

        b = 0;
        while (b < np) begin
            if ($urandom_range(0, 3) == 0) begin
                psum_valid = 1'b0;
            end else begin
                drive_beat(b);
                psum_valid = 1'b1;
                b++;
            end
            @(negedge clk);
            if (b < np) chk("accum_ov", 64'(out_valid), 64'd0);
        end
        psum_valid = 1'b0;
        chk("lat_ov",  64'(out_valid), 64'd1);
        chk("lat_col", 64'(out_col), 64'd0);

        idx = 0;
        cyc = 0;
        noise_seen = 1'b0;
        while (idx < NCOL && cyc < 200) begin
            if (abort_at >= 0 && idx == abort_at) break;
            chk("drain_ov",   64'(out_valid), 64'd1);
            chk("drain_col",  64'(out_col), 64'(idx));
            chk("drain_data", out_data, 64'(exp_v[idx]));
            chk("drain_last", 64'(out_last), 64'(idx == NCOL - 1));
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (noise) begin
                psum_valid = 1'($urandom_range(0, 1));
                start      = 1'($urandom_range(0, 1));
                num_passes = 8'($urandom_range(1, 4));
                drive_noise();
                if (psum_valid) noise_seen = 1'b1;
            end
            if (rdy) idx++;
            @(negedge clk);
            cyc++;
        end
        psum_valid = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b1;

        if (abort_at >= 0) begin
            chk("abort_reached", 64'(idx), 64'(abort_at));
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_rst");
            @(negedge clk);
            rst_n = 1'b1;
        end else begin
            chk("drain_done", 64'(idx), 64'(NCOL));
            chk("end_busy",   64'(busy), 64'd0);
            chk("end_ov",     64'(out_valid), 64'd0);
            chk("end_drop",   64'(dropped), 64'(noise_seen));
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst_n      = 1'b0;
        start      = 1'b0;
        num_passes = '0;
        psum_valid = 1'b0;
        psums      = '0;
        out_ready  = 1'b1;
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // single pass, psums[c] = c+1
        for (int c = 0; c < NCOL; c++) beat[0][c] = longint'(c + 1);
        run_tile(1, 0, 1'b0, 1'b0, -1);

        // signed multi-pass: 100 - 250 + 7
        for (int c = 0; c < NCOL; c++) begin
            beat[0][c] = 100;
            beat[1][c] = -250;
            beat[2][c] = 7;
        end
        run_tile(3, 0, 1'b0, 1'b0, -1);

        // backpressure pattern
        fill_random(2);
        run_tile(2, 1, 1'b0, 1'b0, -1);

        // start with num_passes == 0 is ignored
        @(negedge clk);
        start      = 1'b1;
        num_passes = 8'd0;
        @(negedge clk);
        start = 1'b0;
        chk("zero_pass_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zero_pass_busy2", 64'(busy), 64'd0);

        // stray beat in IDLE sets dropped
        psum_valid = 1'b1;
        drive_noise();
        @(negedge clk);
        psum_valid = 1'b0;
        chk("idle_drop", 64'(dropped), 64'd1);

        // accepted start clears it; noise during drain (beats and starts)
        fill_random(3);
        run_tile(3, 2, 1'b1, 1'b0, -1);

        // start and stray beat in the same IDLE cycle
        fill_random(2);
        run_tile(2, 0, 1'b0, 1'b1, -1);

        // reset after col 3 transfers, then a fresh tile
        fill_random(2);
        run_tile(2, 0, 1'b0, 1'b0, 4);
        fill_random(1);
        run_tile(1, 0, 1'b0, 1'b0, -1);

        // random tiles
        for (int t = 0; t < 6; t++) begin
            int np;
            np = $urandom_range(1, 6);
            fill_random(np);
            run_tile(np, 2, 1'($urandom_range(0, 1)), 1'b0, -1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
